// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch flushes, EX forwarding
// selects and a data-memory wait FSM with forced release after MEM_TIMEOUT cycles.

module hazard_fwd_sel (
    input  logic [4:0] rs,
    input  logic [4:0] rdM,
    input  logic [4:0] rdW,
    input  logic       reg_writeM,
    input  logic       reg_writeW,
    output logic [1:0] sel
);
    // M wins over W; x0 is hardwired zero and never forwarded
    always_comb begin
        sel = 2'b00;
        if (reg_writeM && rdM != 5'd0 && rdM == rs)
            sel = 2'b10;
        else if (reg_writeW && rdW != 5'd0 && rdW == rs)
            sel = 2'b01;
    end
endmodule

module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1D,
    input  logic [4:0]       rs2D,
    input  logic [4:0]       rs1E,
    input  logic [4:0]       rs2E,
    input  logic [4:0]       rdE,
    input  logic [4:0]       rdM,
    input  logic [4:0]       rdW,
    input  logic             mem_readE,
    input  logic             reg_writeM,
    input  logic             reg_writeW,
    input  logic             pc_srcE,
    input  logic             dmem_reqM,
    input  logic             dmem_ready,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             flushW,
    output logic [1:0]       fwdAE,
    output logic [1:0]       fwdBE,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int NUM_OPS = 2;
    localparam int WC_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0]  WC_MAX  = WC_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] MEM_WAIT = 1'b1;

    logic [0:0]      state;
    logic [WC_W-1:0] wait_cnt;
    logic            mem_stall, lw_stall, tmo_hit;

    logic [NUM_OPS-1:0][4:0] rsE;
    logic [NUM_OPS-1:0][1:0] fwd;

    assign rsE = {rs2E, rs1E};

    always_comb begin
        mem_stall = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            RUN:      mem_stall = dmem_reqM & ~dmem_ready;
            MEM_WAIT: begin
                tmo_hit   = ~dmem_ready & (wait_cnt == WC_MAX);
                mem_stall = ~dmem_ready & (wait_cnt != WC_MAX);
            end
            default:  mem_stall = 1'b0;
        endcase
    end

    assign lw_stall = mem_readE & (rdE != 5'd0) & ((rdE == rs1D) | (rdE == rs2D));

    // Memory wait dominates: a frozen E keeps pc_srcE, so the flush lands on release
    assign stallF      = ~reset & (mem_stall | lw_stall);
    assign stallD      = stallF;
    assign stallE      = ~reset & mem_stall;
    assign stallM      = stallE;
    assign flushW      = stallE;
    assign flushD      = ~reset & pc_srcE & ~mem_stall;
    assign flushE      = ~reset & (pc_srcE | lw_stall) & ~mem_stall;
    assign mem_timeout = ~reset & tmo_hit;

    for (genvar i = 0; i < NUM_OPS; i++) begin : g_fwd
        hazard_fwd_sel u_sel (
            .rs         (rsE[i]),
            .rdM        (rdM),
            .rdW        (rdW),
            .reg_writeM (reg_writeM),
            .reg_writeW (reg_writeW),
            .sel        (fwd[i])
        );
    end

    assign fwdAE = reset ? 2'b00 : fwd[0];
    assign fwdBE = reset ? 2'b00 : fwd[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                RUN: if (dmem_reqM && !dmem_ready) begin
                    state    <= MEM_WAIT;
                    wait_cnt <= WC_W'(1);
                end
                MEM_WAIT: if (dmem_ready || wait_cnt == WC_MAX) begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= '0;
        else if (stallF && stall_cnt != CNT_MAX)
            stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the stall/flush/forward rules.

module tb_hazard_ctrl;
    localparam int TMO = 4;
    localparam int CW  = 3;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic mem_readE, reg_writeM, reg_writeW, pc_srcE, dmem_reqM, dmem_ready;
    logic stallF, stallD, stallE, stallM, flushD, flushE, flushW, mem_timeout;
    logic [1:0] fwdAE, fwdBE;
    logic [CW-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    // {stallF,stallD,stallE,stallM, flushD,flushE,flushW, fwdAE, fwdBE, mem_timeout}
    logic [11:0] obs;
    assign obs = {stallF, stallD, stallE, stallM, flushD, flushE, flushW, fwdAE, fwdBE, mem_timeout};

    localparam logic [11:0] NONE   = 12'b0000_000_00_00_0;
    localparam logic [11:0] MEMSTL = 12'b1111_001_00_00_0;

    hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
        .rdE(rdE), .rdM(rdM), .rdW(rdW),
        .mem_readE(mem_readE), .reg_writeM(reg_writeM), .reg_writeW(reg_writeW),
        .pc_srcE(pc_srcE), .dmem_reqM(dmem_reqM), .dmem_ready(dmem_ready),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushW(flushW),
        .fwdAE(fwdAE), .fwdBE(fwdBE), .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
        mem_readE = 0; reg_writeM = 0; reg_writeW = 0; pc_srcE = 0;
        dmem_reqM = 0; dmem_ready = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        rdE = 5; mem_readE = 1; rs1D = 5; pc_srcE = 1; dmem_reqM = 1;
        reg_writeM = 1; rdM = 7; rs1E = 7;
        next_cycle();
        #2;
        checks++; if (obs !== NONE) begin errors++; $display("FAIL reset_outputs got=%b exp=%b", obs, NONE); end
        checks++; if (stall_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
        next_cycle();
        checks++; if (stall_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt_hold got=%0d exp=0", stall_cnt); end
        do_reset();
    endtask

    task automatic test_load_use();
        do_reset();
        rdE = 5; mem_readE = 1; rs1D = 5;
        #2;
        checks++; if (obs !== 12'b1100_010_00_00_0) begin errors++; $display("FAIL lw_rs1 got=%b exp=%b", obs, 12'b1100_010_00_00_0); end
        next_cycle();
        rs1D = 0; rs2D = 5;
        #2;
        checks++; if (obs !== 12'b1100_010_00_00_0) begin errors++; $display("FAIL lw_rs2 got=%b exp=%b", obs, 12'b1100_010_00_00_0); end
        next_cycle();
        rdE = 0; rs1D = 0; rs2D = 0;
        #2;
        checks++; if (obs !== NONE) begin errors++; $display("FAIL lw_x0 got=%b exp=%b", obs, NONE); end
        next_cycle();
        rdE = 5; rs1D = 5; mem_readE = 0;
        #2;
        checks++; if (obs !== NONE) begin errors++; $display("FAIL lw_notload got=%b exp=%b", obs, NONE); end
        next_cycle();
    endtask

    task automatic test_forward();
        do_reset();
        rdM = 7; rdW = 7; reg_writeM = 1; reg_writeW = 1; rs1E = 7; rs2E = 0;
        #2;
        checks++; if (obs !== 12'b0000_000_10_00_0) begin errors++; $display("FAIL fwd_m got=%b", obs); end
        rs2E = 7;
        #2;
        checks++; if (obs !== 12'b0000_000_10_10_0) begin errors++; $display("FAIL fwd_m_both got=%b", obs); end
        reg_writeM = 0;
        #2;
        checks++; if (obs !== 12'b0000_000_01_01_0) begin errors++; $display("FAIL fwd_w got=%b", obs); end
        reg_writeM = 1; rdM = 3; rs2E = 3;
        #2;
        checks++; if (obs !== 12'b0000_000_01_10_0) begin errors++; $display("FAIL fwd_mixed got=%b", obs); end
        rdM = 0; rdW = 0; rs1E = 0; rs2E = 0;
        #2;
        checks++; if (obs !== NONE) begin errors++; $display("FAIL fwd_x0 got=%b", obs); end
        next_cycle();
    endtask

    task automatic test_mem_wait();
        do_reset();
        dmem_reqM = 1; dmem_ready = 0;
        for (int c = 0; c < 3; c++) begin
            #2;
            checks++; if (obs !== MEMSTL) begin errors++; $display("FAIL memwait_c%0d got=%b exp=%b", c, obs, MEMSTL); end
            next_cycle();
        end
        dmem_ready = 1;
        #2;
        checks++; if (obs !== NONE) begin errors++; $display("FAIL memwait_release got=%b", obs); end
        next_cycle();
        dmem_reqM = 1; dmem_ready = 1;
        #2;
        checks++; if (obs !== NONE) begin errors++; $display("FAIL zero_wait got=%b", obs); end
        next_cycle();
        dmem_reqM = 0;
    endtask

    task automatic test_timeout();
        do_reset();
        dmem_reqM = 1; dmem_ready = 0;
        for (int c = 1; c <= TMO; c++) begin
            #2;
            checks++; if (obs !== MEMSTL) begin errors++; $display("FAIL tmo_stall_c%0d got=%b exp=%b", c, obs, MEMSTL); end
            next_cycle();
        end
        #2;
        checks++; if (obs !== 12'b0000_000_00_00_1) begin errors++; $display("FAIL tmo_pulse got=%b", obs); end
        next_cycle();
        dmem_reqM = 0;
        #2;
        checks++; if (obs !== NONE) begin errors++; $display("FAIL tmo_after got=%b", obs); end
        next_cycle();
    endtask

    task automatic test_branch_wait();
        do_reset();
        dmem_reqM = 1; dmem_ready = 0; pc_srcE = 1;
        for (int c = 0; c < 2; c++) begin
            #2;
            checks++; if (obs !== MEMSTL) begin errors++; $display("FAIL br_wait_c%0d got=%b exp=%b", c, obs, MEMSTL); end
            next_cycle();
        end
        dmem_ready = 1;
        #2;
        checks++; if (obs !== 12'b0000_110_00_00_0) begin errors++; $display("FAIL br_release got=%b", obs); end
        next_cycle();
        clear_inputs();
        rdE = 4; mem_readE = 1; rs2D = 4; pc_srcE = 1;
        #2;
        checks++; if (obs !== 12'b1100_110_00_00_0) begin errors++; $display("FAIL br_loaduse got=%b", obs); end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_saturate();
        do_reset();
        rdE = 5; mem_readE = 1; rs1D = 5;
        for (int i = 0; i < 10; i++) begin
            #2;
            checks++; if (stall_cnt !== CW'((i > 7) ? 7 : i)) begin errors++; $display("FAIL sat_i%0d got=%0d exp=%0d", i, stall_cnt, (i > 7) ? 7 : i); end
            next_cycle();
        end
        checks++; if (stall_cnt !== 3'd7) begin errors++; $display("FAIL sat_final got=%0d exp=7", stall_cnt); end
        reset = 1;
        next_cycle();
        checks++; if (stall_cnt !== 3'd0) begin errors++; $display("FAIL sat_reset got=%0d exp=0", stall_cnt); end
        reset = 0;
        clear_inputs();
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        dmem_reqM = 1; dmem_ready = 0;
        next_cycle();
        next_cycle();
        reset = 1;
        next_cycle();
        reset = 0; dmem_reqM = 0; dmem_ready = 0;
        #2;
        checks++; if (obs !== NONE) begin errors++; $display("FAIL rst_midwait got=%b", obs); end
        checks++; if (stall_cnt !== 3'd0) begin errors++; $display("FAIL rst_midwait_cnt got=%0d", stall_cnt); end
        next_cycle();
    endtask

    // Model: how many stall cycles the current memory access has consumed
    task automatic test_random();
        bit   waiting;
        int   spent, cnt;
        bit   ms, lw, tmo;
        logic [1:0] ea, eb;
        logic [11:0] exp;
        do_reset();
        waiting = 0; spent = 0; cnt = 0;
        for (int n = 0; n < 400; n++) begin
            rs1D = 5'($urandom_range(0, 3)); rs2D = 5'($urandom_range(0, 3));
            rs1E = 5'($urandom_range(0, 3)); rs2E = 5'($urandom_range(0, 3));
            rdE  = 5'($urandom_range(0, 3)); rdM  = 5'($urandom_range(0, 3));
            rdW  = 5'($urandom_range(0, 3));
            mem_readE  = 1'($urandom_range(0, 1)); reg_writeM = 1'($urandom_range(0, 1));
            reg_writeW = 1'($urandom_range(0, 1)); pc_srcE    = ($urandom_range(0, 3) == 0);
            dmem_reqM  = 1'($urandom_range(0, 1)); dmem_ready = ($urandom_range(0, 3) == 0);
            if (waiting) begin
                ms  = !dmem_ready && spent < TMO;
                tmo = !dmem_ready && spent == TMO;
            end else begin
                ms  = dmem_reqM && !dmem_ready;
                tmo = 0;
            end
            lw = mem_readE && rdE != 0 && (rdE == rs1D || rdE == rs2D);
            ea = (reg_writeM && rdM != 0 && rdM == rs1E) ? 2'b10 :
                 (reg_writeW && rdW != 0 && rdW == rs1E) ? 2'b01 : 2'b00;
            eb = (reg_writeM && rdM != 0 && rdM == rs2E) ? 2'b10 :
                 (reg_writeW && rdW != 0 && rdW == rs2E) ? 2'b01 : 2'b00;
            exp = {ms | lw, ms | lw, ms, ms, pc_srcE & ~ms, (pc_srcE | lw) & ~ms, ms, ea, eb, tmo};
            #2;
            checks++; if (obs !== exp) begin errors++; $display("FAIL rand_n%0d got=%b exp=%b", n, obs, exp); end
            checks++; if (stall_cnt !== CW'(cnt)) begin errors++; $display("FAIL rand_cnt_n%0d got=%0d exp=%0d", n, stall_cnt, cnt); end
            if (waiting) begin
                if (dmem_ready || spent == TMO) waiting = 0;
                else spent++;
            end else if (dmem_reqM && !dmem_ready) begin
                waiting = 1; spent = 1;
            end
            if (ms || lw) cnt = (cnt + 1 > 7) ? 7 : cnt + 1;
            next_cycle();
        end
        clear_inputs();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        #1;
        test_reset();
        test_load_use();
        test_forward();
        test_mem_wait();
        test_timeout();
        test_branch_wait();
        test_saturate();
        test_reset_mid_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
